// File: rtl/id_exe_stage_reg.sv
// id_exe_stage_reg: ID/EXE pipeline register of the ARM 5-stage pipeline.
// Latches the packed control word and unpacks it into individual control
// outputs. Also latches operands, immediates, destination and status flags.
// The register supports stall (hold), flush (zero everything) and bubble or
// failed condition (zero the control fields, keep the data fields).
// Optional build macro: FORWARDING_EN registers src1/src2/two_src for the
// forwarding unit. When it is undefined, those outputs are constant 0.
module id_exe_stage_reg #(
    parameter int WORD_W = 32,
    parameter int CTRL_W = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              bubble,
    input  logic              cond_pass,
    input  logic [CTRL_W-1:0] ctrl_in,
    input  logic [WORD_W-1:0] pc_in,
    input  logic [WORD_W-1:0] val_rn_in,
    input  logic [WORD_W-1:0] val_rm_in,
    input  logic              imm_in,
    input  logic [11:0]       shift_operand_in,
    input  logic [23:0]       signed_imm_24_in,
    input  logic [3:0]        dest_in,
    input  logic [3:0]        src1_in,
    input  logic [3:0]        src2_in,
    input  logic              two_src_in,
    input  logic [3:0]        status_in,
    output logic              wb_en_out,
    output logic              mem_r_en_out,
    output logic              mem_w_en_out,
    output logic              b_out,
    output logic              s_out,
    output logic [3:0]        exe_cmd_out,
    output logic              valid_out,
    output logic [WORD_W-1:0] pc_out,
    output logic [WORD_W-1:0] val_rn_out,
    output logic [WORD_W-1:0] val_rm_out,
    output logic              imm_out,
    output logic [11:0]       shift_operand_out,
    output logic [23:0]       signed_imm_24_out,
    output logic [3:0]        dest_out,
    output logic [3:0]        status_out,
    output logic [3:0]        src1_out,
    output logic [3:0]        src2_out,
    output logic              two_src_out
);

    typedef enum logic [1:0] {
        SEL_HOLD  = 2'd0,
        SEL_FLUSH = 2'd1,
        SEL_KILL  = 2'd2,
        SEL_LOAD  = 2'd3
    } sel_e;

    // A store must never also write back: mem_w_en (bit 2) clears wb_en (bit 0).
    function automatic logic [CTRL_W-1:0] sanitize_ctrl(input logic [CTRL_W-1:0] c);
        logic [CTRL_W-1:0] r;
        r = c;
        if (c[2]) begin
            r[0] = 1'b0;
        end else begin
            r[0] = c[0];
        end
        return r;
    endfunction

    sel_e              sel_s;
    logic [CTRL_W-1:0] ctrl_r,   ctrl_nxt_s;
    logic              valid_r,  valid_nxt_s;
    logic [WORD_W-1:0] pc_r,     pc_nxt_s;
    logic [WORD_W-1:0] rn_r,     rn_nxt_s;
    logic [WORD_W-1:0] rm_r,     rm_nxt_s;
    logic              imm_r,    imm_nxt_s;
    logic [11:0]       shop_r,   shop_nxt_s;
    logic [23:0]       simm_r,   simm_nxt_s;
    logic [3:0]        dest_r,   dest_nxt_s;
    logic [3:0]        status_r, status_nxt_s;

    // Priority select for this edge: stall > flush > bubble/cond fail > load.
    always_comb begin
        sel_s = SEL_LOAD;
        if (stall) begin
            sel_s = SEL_HOLD;
        end else if (flush) begin
            sel_s = SEL_FLUSH;
        end else if (bubble || !cond_pass) begin
            sel_s = SEL_KILL;
        end else begin
            sel_s = SEL_LOAD;
        end
    end

    // Next-state values of the control and data registers for the chosen action.
    always_comb begin
        ctrl_nxt_s   = ctrl_r;
        valid_nxt_s  = valid_r;
        pc_nxt_s     = pc_r;
        rn_nxt_s     = rn_r;
        rm_nxt_s     = rm_r;
        imm_nxt_s    = imm_r;
        shop_nxt_s   = shop_r;
        simm_nxt_s   = simm_r;
        dest_nxt_s   = dest_r;
        status_nxt_s = status_r;
        case (sel_s)
            SEL_HOLD: begin
                ctrl_nxt_s = ctrl_r;
            end
            SEL_FLUSH: begin
                ctrl_nxt_s   = {CTRL_W{1'b0}};
                valid_nxt_s  = 1'b0;
                pc_nxt_s     = {WORD_W{1'b0}};
                rn_nxt_s     = {WORD_W{1'b0}};
                rm_nxt_s     = {WORD_W{1'b0}};
                imm_nxt_s    = 1'b0;
                shop_nxt_s   = 12'd0;
                simm_nxt_s   = 24'd0;
                dest_nxt_s   = 4'd0;
                status_nxt_s = 4'd0;
            end
            SEL_KILL, SEL_LOAD: begin
                if (sel_s == SEL_LOAD) begin
                    ctrl_nxt_s  = sanitize_ctrl(ctrl_in);
                    valid_nxt_s = 1'b1;
                end else begin
                    ctrl_nxt_s  = {CTRL_W{1'b0}};
                    valid_nxt_s = 1'b0;
                end
                pc_nxt_s     = pc_in;
                rn_nxt_s     = val_rn_in;
                rm_nxt_s     = val_rm_in;
                imm_nxt_s    = imm_in;
                shop_nxt_s   = shift_operand_in;
                simm_nxt_s   = signed_imm_24_in;
                dest_nxt_s   = dest_in;
                status_nxt_s = status_in;
            end
            default: begin
                ctrl_nxt_s = ctrl_r;
            end
        endcase
    end

    // Pipeline register bank with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_r   <= {CTRL_W{1'b0}};
            valid_r  <= 1'b0;
            pc_r     <= {WORD_W{1'b0}};
            rn_r     <= {WORD_W{1'b0}};
            rm_r     <= {WORD_W{1'b0}};
            imm_r    <= 1'b0;
            shop_r   <= 12'd0;
            simm_r   <= 24'd0;
            dest_r   <= 4'd0;
            status_r <= 4'd0;
        end else begin
            ctrl_r   <= ctrl_nxt_s;
            valid_r  <= valid_nxt_s;
            pc_r     <= pc_nxt_s;
            rn_r     <= rn_nxt_s;
            rm_r     <= rm_nxt_s;
            imm_r    <= imm_nxt_s;
            shop_r   <= shop_nxt_s;
            simm_r   <= simm_nxt_s;
            dest_r   <= dest_nxt_s;
            status_r <= status_nxt_s;
        end
    end

    assign s_out             = ctrl_r[8];
    assign b_out             = ctrl_r[7];
    assign exe_cmd_out       = ctrl_r[6:3];
    assign mem_w_en_out      = ctrl_r[2];
    assign mem_r_en_out      = ctrl_r[1];
    assign wb_en_out         = ctrl_r[0];
    assign valid_out         = valid_r;
    assign pc_out            = pc_r;
    assign val_rn_out        = rn_r;
    assign val_rm_out        = rm_r;
    assign imm_out           = imm_r;
    assign shift_operand_out = shop_r;
    assign signed_imm_24_out = simm_r;
    assign dest_out          = dest_r;
    assign status_out        = status_r;

`ifdef FORWARDING_EN
    logic [3:0] src1_r, src1_nxt_s;
    logic [3:0] src2_r, src2_nxt_s;
    logic       two_r,  two_nxt_s;

    // Forwarding indices follow the same hold/zero/load rules, zeroed on any kill.
    always_comb begin
        src1_nxt_s = src1_r;
        src2_nxt_s = src2_r;
        two_nxt_s  = two_r;
        case (sel_s)
            SEL_LOAD: begin
                src1_nxt_s = src1_in;
                src2_nxt_s = src2_in;
                two_nxt_s  = two_src_in;
            end
            SEL_FLUSH, SEL_KILL: begin
                src1_nxt_s = 4'd0;
                src2_nxt_s = 4'd0;
                two_nxt_s  = 1'b0;
            end
            default: begin
                src1_nxt_s = src1_r;
            end
        endcase
    end

    // Forwarding index registers with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            src1_r <= 4'd0;
            src2_r <= 4'd0;
            two_r  <= 1'b0;
        end else begin
            src1_r <= src1_nxt_s;
            src2_r <= src2_nxt_s;
            two_r  <= two_nxt_s;
        end
    end

    assign src1_out    = src1_r;
    assign src2_out    = src2_r;
    assign two_src_out = two_r;
`else
    logic unused_fwd_s;
    assign unused_fwd_s = ^{src1_in, src2_in, two_src_in};
    assign src1_out     = 4'd0;
    assign src2_out     = 4'd0;
    assign two_src_out  = 1'b0;
`endif

endmodule

// File: tb/tb_id_exe_stage_reg.sv
// Self-checking bench for id_exe_stage_reg: directed scenarios plus a
// randomized run, all checked against a rule-level reference model.
module tb_id_exe_stage_reg;

    localparam int WORD_W = 32;
    localparam int OBS_W  = 10 + 3 * WORD_W + 45 + 9;

    localparam logic [8:0] C_ADD = 9'b0_0_0010_0_0_1;
    localparam logic [8:0] C_LDR = 9'b0_0_0010_0_1_1;
    localparam logic [8:0] C_MOV = 9'b0_0_0001_0_0_1;
    localparam logic [8:0] C_STR = 9'b0_0_0010_1_0_0;
    localparam logic [8:0] C_B   = 9'b0_1_0000_0_0_0;

    logic              clk, rst, stall, flush, bubble, cond_pass;
    logic [8:0]        ctrl_in;
    logic [WORD_W-1:0] pc_in, val_rn_in, val_rm_in;
    logic              imm_in, two_src_in;
    logic [11:0]       shift_operand_in;
    logic [23:0]       signed_imm_24_in;
    logic [3:0]        dest_in, src1_in, src2_in, status_in;
    logic              wb_en_out, mem_r_en_out, mem_w_en_out, b_out, s_out, valid_out;
    logic [3:0]        exe_cmd_out, dest_out, status_out, src1_out, src2_out;
    logic [WORD_W-1:0] pc_out, val_rn_out, val_rm_out;
    logic              imm_out, two_src_out;
    logic [11:0]       shift_operand_out;
    logic [23:0]       signed_imm_24_out;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state: what each output should show.
    logic              e_valid, e_s, e_b, e_mw, e_mr, e_wb, e_imm, e_two;
    logic [3:0]        e_cmd, e_dest, e_status, e_src1, e_src2;
    logic [WORD_W-1:0] e_pc, e_rn, e_rm;
    logic [11:0]       e_shop;
    logic [23:0]       e_simm;

    id_exe_stage_reg #(.WORD_W(WORD_W), .CTRL_W(9)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .bubble(bubble),
        .cond_pass(cond_pass), .ctrl_in(ctrl_in), .pc_in(pc_in),
        .val_rn_in(val_rn_in), .val_rm_in(val_rm_in), .imm_in(imm_in),
        .shift_operand_in(shift_operand_in), .signed_imm_24_in(signed_imm_24_in),
        .dest_in(dest_in), .src1_in(src1_in), .src2_in(src2_in),
        .two_src_in(two_src_in), .status_in(status_in),
        .wb_en_out(wb_en_out), .mem_r_en_out(mem_r_en_out),
        .mem_w_en_out(mem_w_en_out), .b_out(b_out), .s_out(s_out),
        .exe_cmd_out(exe_cmd_out), .valid_out(valid_out), .pc_out(pc_out),
        .val_rn_out(val_rn_out), .val_rm_out(val_rm_out), .imm_out(imm_out),
        .shift_operand_out(shift_operand_out), .signed_imm_24_out(signed_imm_24_out),
        .dest_out(dest_out), .status_out(status_out), .src1_out(src1_out),
        .src2_out(src2_out), .two_src_out(two_src_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [OBS_W-1:0] dut_vec();
        return {valid_out, s_out, b_out, exe_cmd_out, mem_w_en_out, mem_r_en_out,
                wb_en_out, pc_out, val_rn_out, val_rm_out, imm_out, shift_operand_out,
                signed_imm_24_out, dest_out, status_out, src1_out, src2_out, two_src_out};
    endfunction

    function automatic logic [OBS_W-1:0] exp_vec();
        return {e_valid, e_s, e_b, e_cmd, e_mw, e_mr, e_wb, e_pc, e_rn, e_rm, e_imm,
                e_shop, e_simm, e_dest, e_status, e_src1, e_src2, e_two};
    endfunction

    task automatic model_zero();
        {e_valid, e_s, e_b, e_cmd, e_mw, e_mr, e_wb} = 10'd0;
        e_pc = 32'd0; e_rn = 32'd0; e_rm = 32'd0; e_imm = 1'b0;
        e_shop = 12'd0; e_simm = 24'd0; e_dest = 4'd0; e_status = 4'd0;
        e_src1 = 4'd0; e_src2 = 4'd0; e_two = 1'b0;
    endtask

    // Apply the architectural rules for one rising edge using current inputs.
    task automatic model_edge();
        if (stall) begin
            // everything holds
        end else if (flush) begin
            model_zero();
        end else begin
            e_pc = pc_in; e_rn = val_rn_in; e_rm = val_rm_in; e_imm = imm_in;
            e_shop = shift_operand_in; e_simm = signed_imm_24_in;
            e_dest = dest_in; e_status = status_in;
            if (bubble || !cond_pass) begin
                {e_valid, e_s, e_b, e_cmd, e_mw, e_mr, e_wb} = 10'd0;
                e_src1 = 4'd0; e_src2 = 4'd0; e_two = 1'b0;
            end else begin
                e_valid = 1'b1;
                e_s = ctrl_in[8]; e_b = ctrl_in[7]; e_cmd = ctrl_in[6:3];
                e_mw = ctrl_in[2]; e_mr = ctrl_in[1];
                e_wb = ctrl_in[0] && !ctrl_in[2];
`ifdef FORWARDING_EN
                e_src1 = src1_in; e_src2 = src2_in; e_two = two_src_in;
`else
                e_src1 = 4'd0; e_src2 = 4'd0; e_two = 1'b0;
`endif
            end
        end
    endtask

    // Advance one edge; model updated from the inputs held stable across it.
    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [8:0] c);
        logic [31:0] r;
        ctrl_in = c;
        r = $urandom; pc_in = r;
        r = $urandom; val_rn_in = r;
        r = $urandom; val_rm_in = r;
        r = $urandom;
        imm_in = r[0]; shift_operand_in = r[12:1]; dest_in = r[16:13];
        src1_in = r[20:17]; src2_in = r[24:21]; two_src_in = r[25]; status_in = r[29:26];
        r = $urandom; signed_imm_24_in = r[23:0];
        stall = 1'b0; flush = 1'b0; bubble = 1'b0; cond_pass = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_instr(C_ADD);
        model_zero();
        #2;
        n_cmp++;
        if (dut_vec() !== {OBS_W{1'b0}}) begin
            n_bad++; $display("FAIL reset_state got=%h want=0", dut_vec());
        end
        @(posedge clk); #1;
        n_cmp++;
        if (dut_vec() !== {OBS_W{1'b0}}) begin
            n_bad++; $display("FAIL reset_held got=%h want=0", dut_vec());
        end
        rst = 1'b0;
    endtask

    task automatic test_normal_load();
        set_instr(C_ADD);
        val_rn_in = 32'd5; dest_in = 4'd3;
        tick();
        n_cmp++;
        if ({exe_cmd_out, wb_en_out, val_rn_out, dest_out, valid_out} !==
            {4'b0010, 1'b1, 32'd5, 4'd3, 1'b1}) begin
            n_bad++; $display("FAIL add_load cmd=%b wb=%b rn=%0d dest=%0d v=%b want 0010/1/5/3/1",
                              exe_cmd_out, wb_en_out, val_rn_out, dest_out, valid_out);
        end
        n_cmp++;
        if (dut_vec() !== exp_vec()) begin
            n_bad++; $display("FAIL add_full got=%h want=%h", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_stall();
        set_instr(C_LDR);
        tick();
        n_cmp++;
        if (mem_r_en_out !== 1'b1) begin
            n_bad++; $display("FAIL ldr_load mem_r=%b want 1", mem_r_en_out);
        end
        for (int i = 0; i < 3; i++) begin
            set_instr(C_MOV);
            stall = 1'b1; flush = (i == 1); bubble = (i == 2);
            tick();
            n_cmp++;
            if (mem_r_en_out !== 1'b1 || exe_cmd_out !== 4'b0010 || dut_vec() !== exp_vec()) begin
                n_bad++; $display("FAIL stall_hold%0d got=%h want=%h", i, dut_vec(), exp_vec());
            end
        end
        stall = 1'b0; flush = 1'b0; bubble = 1'b0;
        tick();
        n_cmp++;
        if (exe_cmd_out !== 4'b0001 || valid_out !== 1'b1 || mem_r_en_out !== 1'b0) begin
            n_bad++; $display("FAIL stall_release cmd=%b v=%b mr=%b want 0001/1/0",
                              exe_cmd_out, valid_out, mem_r_en_out);
        end
    endtask

    task automatic test_flush();
        set_instr(C_STR);
        dest_in = 4'd7; flush = 1'b1;
        tick();
        n_cmp++;
        if (mem_w_en_out !== 1'b0 || dest_out !== 4'd0 || valid_out !== 1'b0) begin
            n_bad++; $display("FAIL flush_str mw=%b dest=%0d v=%b want 0/0/0",
                              mem_w_en_out, dest_out, valid_out);
        end
        set_instr(C_ADD);
        tick();
        set_instr(C_ADD);
        flush = 1'b1; bubble = 1'b1;
        tick();
        n_cmp++;
        if (dut_vec() !== {OBS_W{1'b0}}) begin
            n_bad++; $display("FAIL flush_bubble got=%h want=0", dut_vec());
        end
    endtask

    task automatic test_bubble();
        set_instr(C_ADD);
        val_rm_in = 32'd9; bubble = 1'b1;
        tick();
        n_cmp++;
        if (wb_en_out !== 1'b0 || valid_out !== 1'b0 || val_rm_out !== 32'd9) begin
            n_bad++; $display("FAIL bubble_add wb=%b v=%b rm=%0d want 0/0/9",
                              wb_en_out, valid_out, val_rm_out);
        end
        set_instr(C_B);
        cond_pass = 1'b0;
        tick();
        n_cmp++;
        if (b_out !== 1'b0 || valid_out !== 1'b0 || dut_vec() !== exp_vec()) begin
            n_bad++; $display("FAIL cond_fail_b got=%h want=%h", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_async_reset();
        set_instr(C_ADD);
        tick();
        set_instr(C_MOV);
        stall = 1'b1;
        tick();
        n_cmp++;
        if (valid_out !== 1'b1) begin
            n_bad++; $display("FAIL pre_reset_valid got=%b want 1", valid_out);
        end
        rst = 1'b1;
        model_zero();
        #1;
        n_cmp++;
        if (dut_vec() !== {OBS_W{1'b0}}) begin
            n_bad++; $display("FAIL async_reset got=%h want=0", dut_vec());
        end
        #1;
        rst = 1'b0; stall = 1'b0;
        tick();
        n_cmp++;
        if (exe_cmd_out !== 4'b0001 || valid_out !== 1'b1 || dut_vec() !== exp_vec()) begin
            n_bad++; $display("FAIL post_reset_load got=%h want=%h", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_integrity();
        set_instr(9'b1_1_1111_1_1_1);
        tick();
        n_cmp++;
        if (mem_w_en_out !== 1'b1 || wb_en_out !== 1'b0) begin
            n_bad++; $display("FAIL ctrl_integrity mw=%b wb=%b want 1/0", mem_w_en_out, wb_en_out);
        end
    endtask

    task automatic test_forwarding();
        logic [8:0] want;
        set_instr(C_ADD);
        src1_in = 4'd2; src2_in = 4'd4; two_src_in = 1'b1;
        tick();
`ifdef FORWARDING_EN
        want = {4'd2, 4'd4, 1'b1};
`else
        want = 9'd0;
`endif
        n_cmp++;
        if ({src1_out, src2_out, two_src_out} !== want) begin
            n_bad++; $display("FAIL fwd_load got=%h want=%h", {src1_out, src2_out, two_src_out}, want);
        end
        bubble = 1'b1;
        tick();
        n_cmp++;
        if ({src1_out, src2_out, two_src_out} !== 9'd0) begin
            n_bad++; $display("FAIL fwd_bubble got=%h want=0", {src1_out, src2_out, two_src_out});
        end
    endtask

    task automatic test_random();
        logic [31:0] r;
        for (int i = 0; i < 400; i++) begin
            r = $urandom;
            set_instr(r[8:0]);
            r = $urandom;
            stall = (r[1:0] == 2'd0);
            flush = (r[4:2] == 3'd0);
            bubble = (r[7:5] == 3'd0);
            cond_pass = (r[10:8] != 3'd0);
            tick();
            n_cmp++;
            if (dut_vec() !== exp_vec()) begin
                n_bad++; $display("FAIL random_%0d got=%h want=%h", i, dut_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_normal_load();
        test_stall();
        test_flush();
        test_bubble();
        test_async_reset();
        test_integrity();
        test_forwarding();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/id_exe_stage_reg.md
Name: id_exe_stage_reg

Overview:
- Pipeline register between the decode stage (control unit, register file, condition check) and the execute stage of the ARM 5-stage pipeline.
- Latches the 9-bit packed control word and unpacks it into individual control outputs.
- Latches operands, immediate fields, destination and status flags.
- Supports stall (hold), flush (branch-taken kill) and bubble insertion (hazard / failed condition).

Parameters:
- WORD_W, 32, width of PC and register operands.
- CTRL_W, 9, width of packed control word; fixed at 9, other values unsupported.

Ports:
- clk  input  1  pipeline clock, rising edge.
- rst  input  1  reset; asynchronous, active-high.
- stall  input  1  global freeze (memory wait); hold every register.
- flush  input  1  branch taken in EXE; kill the instruction entering EXE.
- bubble  input  1  hazard detected; insert a NOP into EXE.
- cond_pass  input  1  condition check result for the decoded instruction.
- ctrl_in  input  9  packed {S, B, EXE_CMD[3:0], MEM_W_EN, MEM_R_EN, WB_EN}, bit 8 down to 0.
- pc_in  input  WORD_W  PC+4 of the decoded instruction.
- val_rn_in  input  WORD_W  Rn operand value.
- val_rm_in  input  WORD_W  Rm operand value.
- imm_in  input  1  I bit.
- shift_operand_in  input  12  shifter operand field.
- signed_imm_24_in  input  24  branch offset.
- dest_in  input  4  destination register index.
- src1_in, src2_in  input  4 each  source register indices.
- two_src_in  input  1  instruction reads Rm or is STR.
- status_in  input  4  NZCV from the status register.
- wb_en_out, mem_r_en_out, mem_w_en_out, b_out, s_out  output  1 each  unpacked control.
- exe_cmd_out  output  4  ALU command.
- valid_out  output  1  registered instruction is live (not a bubble or flush).
- pc_out, val_rn_out, val_rm_out  output  WORD_W  registered data.
- imm_out, shift_operand_out, signed_imm_24_out, dest_out, status_out  output  matching widths  registered data.
- src1_out, src2_out, two_src_out  output  4/4/1  forwarding info; see Optional Feature.

Behaviour:
- Reset: asynchronous, active-high. Every output register is forced to 0 immediately, including valid_out=0 and exe_cmd_out=4'b0000.
- All outputs are registered; latency is 1 clk from input to output. There is no combinational path from input to output.
- Priority per rising edge, highest first: stall > flush > (bubble | ~cond_pass) > normal load.
- stall=1:
  - All registers hold, including valid_out.
  - flush and bubble are ignored; upstream keeps them asserted until stall drops.
- flush=1 (no stall):
  - All control outputs go to 0, valid_out=0.
  - Data registers go to 0 and dest_out=0, so forwarding never matches stale data.
- bubble=1 or cond_pass=0 (no stall/flush):
  - Control outputs go to 0 and valid_out=0.
  - Data fields still load from inputs, which keeps bench traces readable.
  - The instruction is architecturally dead: no WB, no memory access, no status update, no branch.
- Normal load:
  - Unpack ctrl_in: s_out=ctrl_in[8], b_out=ctrl_in[7], exe_cmd_out=ctrl_in[6:3], mem_w_en_out=ctrl_in[2], mem_r_en_out=ctrl_in[1], wb_en_out=ctrl_in[0].
  - Load all data fields; valid_out=1.
- Simultaneous flush and bubble: flush wins, producing the full zero state.
- Reset asserted mid-stall: outputs clear at once. After release, the first edge with stall=0 loads normally.
- Control-word integrity: mem_w_en_out and wb_en_out are never both 1. If ctrl_in violates this, mem_w_en_out wins and wb_en_out is forced to 0.

Optional Feature:
- Macro: FORWARDING_EN.
- Defined: src1_out, src2_out and two_src_out are registered under the same stall/flush/bubble rules. On flush or bubble they are zeroed, with two_src_out=0.
- Undefined: src1_out, src2_out and two_src_out are tied to constant 0 and no flops are inferred. Other outputs are unaffected.

Test Plan:
- Reset then normal load: rst=1 -> all outputs 0. Release rst, apply ctrl_in=9'b0_0_0010_0_0_1 (ADD), val_rn_in=5, dest_in=3, cond_pass=1 -> next edge: exe_cmd_out=0010, wb_en_out=1, val_rn_out=5, dest_out=3, valid_out=1.
- Stall hold: load LDR control (9'b0_0_0010_0_1_1), then stall=1 for 3 cycles while ctrl_in changes to MOV -> outputs remain LDR (mem_r_en_out=1) for all 3 cycles. Drop stall -> MOV (exe_cmd_out=0001) appears one edge later.
- Flush: flush=1 with STR (ctrl_in=9'b0_0_0010_1_0_0), dest_in=7 -> mem_w_en_out=0, dest_out=0, valid_out=0. Flush+bubble together -> same zero state.
- Bubble / condition fail: bubble=1 with ADD, val_rm_in=9 -> wb_en_out=0, valid_out=0, val_rm_out=9. Then cond_pass=0 with B (ctrl_in bit7=1) -> b_out=0.
- Async reset mid-operation: assert rst between edges while stall=1 and valid_out=1 -> outputs 0 before the next edge. Release -> next edge loads.
- FORWARDING_EN both builds: src1_in=2, src2_in=4, two_src_in=1 -> defined: outputs 2/4/1 after one edge, and 0/0/0 after a bubble. Undefined: outputs constant 0.
